// File: rtl/mips_defs.sv
// Shared MIPS core constants: exception vector, ERET cause bit, stage indices
// and the redirect FSM state type.
package mips_defs;

    localparam int          NUM_STAGES_DEFAULT = 6;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hbfc00380;
    localparam int          ERET_BIT_DEFAULT   = 12;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_PEND = 1'b1
    } redir_state_e;

endpackage

// File: rtl/stall_encoder.sv
// Turns per-stage stall requests into a thermometer vector: the highest
// requesting stage and every stage before it stall. The last stage never stalls.
module stall_encoder #(
    parameter int NUM_STAGES = 6
) (
    input  logic [NUM_STAGES-1:0] stallreq_i,
    output logic [NUM_STAGES-1:0] stall_o
);

    logic unused_wbReq;
    logic reqSeen;

    assign unused_wbReq = stallreq_i[NUM_STAGES-1];

    // Sweep from the youngest stallable stage down, carrying any request seen.
    always_comb begin
        stall_o = '0;
        reqSeen = 1'b0;
        for (int j = NUM_STAGES - 2; j >= 0; j--) begin
            reqSeen    = reqSeen | stallreq_i[j];
            stall_o[j] = reqSeen;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall thermometer, exception flush, a redirect held
// until fetch accepts it, and a sticky watchdog for stalls that never clear.
module pipe_ctrl
    import mips_defs::*;
#(
    parameter int          NUM_STAGES = NUM_STAGES_DEFAULT,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
    parameter int          ERET_BIT   = ERET_BIT_DEFAULT,
    parameter int          WDOG_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] stallreq_i,
    input  logic [31:0]           excepttype_i,
    input  logic [31:0]           cp0_epc_i,
    input  logic                  redirect_ready_i,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic                  flush_o,
    output logic                  redirect_valid_o,
    output logic [31:0]           redirect_pc_o,
    output logic                  wdog_o
);

    redir_state_e          state_q, state_d;
    logic [31:0]           redirPc_q, redirPc_d;
    logic [WDOG_W-1:0]     wdogCnt_q, wdogCnt_d;
    logic                  wdog_q, wdog_d;
    logic [NUM_STAGES-1:0] thermStall;
    logic [NUM_STAGES-1:0] stallVec;
    logic                  exc;
    logic [31:0]           target;

    assign exc    = |excepttype_i;
    assign target = excepttype_i[ERET_BIT] ? cp0_epc_i : EXC_VECTOR;

    stall_encoder #(
        .NUM_STAGES(NUM_STAGES)
    ) u_stallEncoder (
        .stallreq_i(stallreq_i),
        .stall_o   (thermStall)
    );

    // An exception cancels all stalls; a pending redirect keeps the PC frozen.
    always_comb begin
        stallVec = '0;
        if (!rst && !exc) begin
            stallVec = thermStall;
            if (state_q == RD_PEND) begin
                stallVec[STG_PC] = 1'b1;
            end
        end
    end

    // The newest exception always overwrites the target, even on a handshake cycle.
    always_comb begin
        state_d   = state_q;
        redirPc_d = redirPc_q;
        unique case (state_q)
            RD_IDLE: begin
                if (exc) begin
                    state_d   = RD_PEND;
                    redirPc_d = target;
                end
            end
            RD_PEND: begin
                if (exc) begin
                    redirPc_d = target;
                end else if (redirect_ready_i) begin
                    state_d = RD_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        wdogCnt_d = wdogCnt_q;
        if (stallVec == '0 || exc) begin
            wdogCnt_d = '0;
        end else if (wdogCnt_q != '1) begin
            wdogCnt_d = wdogCnt_q + WDOG_W'(1);
        end
        wdog_d = wdog_q | (wdogCnt_d == '1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RD_IDLE;
            redirPc_q <= '0;
            wdogCnt_q <= '0;
            wdog_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            redirPc_q <= redirPc_d;
            wdogCnt_q <= wdogCnt_d;
            wdog_q    <= wdog_d;
        end
    end

    assign stall_o          = stallVec;
    assign flush_o          = exc & ~rst;
    assign redirect_valid_o = (state_q == RD_PEND);
    assign redirect_pc_o    = redirPc_q;
    assign wdog_o           = wdog_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed and randomized checks of pipe_ctrl against a behavioural model of
// the stall, flush, redirect and watchdog rules.
module tb_pipe_ctrl;

    localparam int          NS     = 6;
    localparam int          WW     = 4;
    localparam int          WD_MAX = (1 << WW) - 1;
    localparam logic [31:0] VEC    = 32'hbfc00380;
    localparam logic [31:0] EPC    = 32'h8000_0040;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] stallreq_i;
    logic [31:0]   excepttype_i;
    logic [31:0]   cp0_epc_i;
    logic          redirect_ready_i;
    logic [NS-1:0] stall_o;
    logic          flush_o;
    logic          redirect_valid_o;
    logic [31:0]   redirect_pc_o;
    logic          wdog_o;

    int testsRun    = 0;
    int testsFailed = 0;

    bit            mPend;
    logic [31:0]   mPc;
    int            mCnt;
    bit            mWdog;
    logic [NS-1:0] eStall;
    logic          eFlush;

    pipe_ctrl #(
        .NUM_STAGES(NS),
        .EXC_VECTOR(VEC),
        .ERET_BIT  (12),
        .WDOG_W    (WW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stallreq_i      (stallreq_i),
        .excepttype_i    (excepttype_i),
        .cp0_epc_i       (cp0_epc_i),
        .redirect_ready_i(redirect_ready_i),
        .stall_o         (stall_o),
        .flush_o         (flush_o),
        .redirect_valid_o(redirect_valid_o),
        .redirect_pc_o   (redirect_pc_o),
        .wdog_o          (wdog_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input bit combToo);
        if (combToo) begin
            testsRun++;
            assert (stall_o === eStall) else begin
                testsFailed++;
                $error("[TB] FAIL %s stall_o got %b expected %b", tag, stall_o, eStall);
            end
            testsRun++;
            assert (flush_o === eFlush) else begin
                testsFailed++;
                $error("[TB] FAIL %s flush_o got %b expected %b", tag, flush_o, eFlush);
            end
        end
        testsRun++;
        assert (redirect_valid_o === mPend) else begin
            testsFailed++;
            $error("[TB] FAIL %s redirect_valid_o got %b expected %b", tag, redirect_valid_o, mPend);
        end
        testsRun++;
        assert (redirect_pc_o === mPc) else begin
            testsFailed++;
            $error("[TB] FAIL %s redirect_pc_o got %h expected %h", tag, redirect_pc_o, mPc);
        end
        testsRun++;
        assert (wdog_o === mWdog) else begin
            testsFailed++;
            $error("[TB] FAIL %s wdog_o got %b expected %b", tag, wdog_o, mWdog);
        end
    endtask

    // One clock: drive on the falling edge, check mid-cycle, advance the model on the rising edge.
    task automatic applyStimulus(input string tag, input logic [NS-1:0] req, input logic [31:0] et,
                                 input logic [31:0] epc, input logic rdy, input logic r);
        bit exc;
        int h;
        @(negedge clk);
        stallreq_i       = req;
        excepttype_i     = et;
        cp0_epc_i        = epc;
        redirect_ready_i = rdy;
        rst              = r;
        #1;
        exc = (et != 32'h0);
        h   = -1;
        for (int k = 0; k < NS - 1; k++) begin
            if (req[k]) h = k;
        end
        if (exc) begin
            eStall = '0;
        end else begin
            eStall = NS'((1 << (h + 1)) - 1);
            if (mPend) eStall[0] = 1'b1;
        end
        eFlush = exc;
        checkOutput(tag, !r);
        @(posedge clk);
        if (r) begin
            mPend = 1'b0;
            mPc   = 32'h0;
            mCnt  = 0;
            mWdog = 1'b0;
        end else begin
            if (exc) begin
                mPend = 1'b1;
                mPc   = et[12] ? epc : VEC;
            end else if (mPend && rdy) begin
                mPend = 1'b0;
            end
            if (eStall == '0 || exc) mCnt = 0;
            else if (mCnt < WD_MAX) mCnt++;
            if (mCnt == WD_MAX) mWdog = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] et;
        rst              = 1'b1;
        stallreq_i       = '0;
        excepttype_i     = '0;
        cp0_epc_i        = '0;
        redirect_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        mPend = 1'b0;
        mPc   = 32'h0;
        mCnt  = 0;
        mWdog = 1'b0;

        applyStimulus("map_bit3",  6'b001000, 32'h0, 32'h0, 1'b0, 1'b0);
        applyStimulus("map_bit31", 6'b001010, 32'h0, 32'h0, 1'b0, 1'b0);
        applyStimulus("map_wb",    6'b100000, 32'h0, 32'h0, 1'b0, 1'b0);

        applyStimulus("exc_take",  6'b010000, 32'h1, 32'h0, 1'b0, 1'b0);
        repeat (3) applyStimulus("exc_hold", 6'b000000, 32'h0, 32'h0, 1'b0, 1'b0);
        applyStimulus("exc_accept", 6'b000000, 32'h0, 32'h0, 1'b1, 1'b0);
        applyStimulus("exc_done",   6'b000000, 32'h0, 32'h0, 1'b0, 1'b0);

        applyStimulus("eret_take", 6'b000000, 32'h1000, EPC, 1'b0, 1'b0);
        applyStimulus("eret_pc",   6'b000000, 32'h0, 32'h0, 1'b1, 1'b0);
        applyStimulus("eret_done", 6'b000000, 32'h0, 32'h0, 1'b0, 1'b0);

        applyStimulus("ovr_take",  6'b000000, 32'h1, 32'h0, 1'b0, 1'b0);
        applyStimulus("ovr_eret",  6'b000000, 32'h1000, EPC, 1'b1, 1'b0);
        applyStimulus("ovr_check", 6'b000000, 32'h0, 32'h0, 1'b1, 1'b0);
        applyStimulus("ovr_done",  6'b000000, 32'h0, 32'h0, 1'b0, 1'b0);

        repeat (14) applyStimulus("wd_short", 6'b000001, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (2) applyStimulus("wd_gap", 6'b000000, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (15) applyStimulus("wd_long", 6'b000100, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (3) applyStimulus("wd_sticky", 6'b000000, 32'h0, 32'h0, 1'b0, 1'b0);

        applyStimulus("rst_take",  6'b000000, 32'h1, 32'h0, 1'b0, 1'b0);
        applyStimulus("rst_mid",   6'b000010, 32'h1000, EPC, 1'b0, 1'b1);
        applyStimulus("rst_after", 6'b000000, 32'h0, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            et = 32'h0;
            if ($urandom_range(5) == 0) begin
                et = ($urandom_range(2) == 0) ? 32'h1000 : (32'h1 << $urandom_range(11));
            end
            applyStimulus("random", NS'($urandom), et, $urandom, 1'($urandom_range(1)),
                          ($urandom_range(63) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
